// File: rtl/fsmc_slave_ctrl.sv
// FSMC slave bus controller: synchronizes the MCU strobes, turns writes into single-cycle
// internal strobes and services reads through the pin buffer's registered output path.
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif

module fsmc_slave_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fsmc_ne,
    input  logic                     fsmc_noe,
    input  logic                     fsmc_nwe,
    input  logic [ADDR_W-1:0]        fsmc_a,
    input  logic [`FSMC_WIDTH-1:0]   buf_outp,
    output logic [`FSMC_WIDTH-1:0]   buf_inp,
    output logic                     buf_oe,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [`FSMC_WIDTH-1:0]   wr_data,
    output logic                     rd_req,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [`FSMC_WIDTH-1:0]   rd_data,
    input  logic                     rd_valid,
    output logic                     bus_err
);

    localparam int DW    = `FSMC_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        READ_REQ   = 3'd2,
        READ_LOAD  = 3'd3,
        READ_DRIVE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    // bit 0: first stage, bit 1: synchronized level, bit 2: previous synchronized level
    logic [2:0]         ne_sync_q, ne_sync_d;
    logic [2:0]         noe_sync_q, noe_sync_d;
    logic [2:0]         nwe_sync_q, nwe_sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DW-1:0]      wr_data_q, wr_data_d;
    logic [DW-1:0]      buf_inp_q, buf_inp_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_req_q, rd_req_d;
    logic               bus_err_q, bus_err_d;
    logic               buf_oe_q, buf_oe_d;

    logic ne_s, noe_s, nwe_s;
    logic noe_fall, nwe_fall, nwe_rise;

    assign ne_s     = ne_sync_q[1];
    assign noe_s    = noe_sync_q[1];
    assign nwe_s    = nwe_sync_q[1];
    assign noe_fall = ~noe_sync_q[1] & noe_sync_q[2];
    assign nwe_fall = ~nwe_sync_q[1] & nwe_sync_q[2];
    assign nwe_rise = nwe_sync_q[1] & ~nwe_sync_q[2];

    // Next-state and output decode.
    always_comb begin
        ne_sync_d  = {ne_sync_q[1:0], fsmc_ne};
        noe_sync_d = {noe_sync_q[1:0], fsmc_noe};
        nwe_sync_d = {nwe_sync_q[1:0], fsmc_nwe};
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_data_d  = wr_data_q;
        buf_inp_d  = buf_inp_q;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        bus_err_d  = 1'b0;
        buf_oe_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!noe_s && !nwe_s && (noe_fall || nwe_fall)) begin
                    bus_err_d = 1'b1;
                end else if (!ne_s && nwe_fall) begin
                    wr_addr_d = fsmc_a;
                    state_d   = WRITE;
                end else if (!ne_s && noe_fall) begin
                    rd_addr_d = fsmc_a;
                    rd_req_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = READ_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (nwe_rise) begin
                    wr_data_d = buf_outp;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end else if (ne_s) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            READ_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (noe_s || ne_s) begin
                    state_d = IDLE;
                end else if (rd_valid) begin
                    buf_inp_d = rd_data;
                    state_d   = READ_LOAD;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    buf_inp_d = {DW{1'b1}};
                    bus_err_d = 1'b1;
                    state_d   = READ_LOAD;
                end else begin
                    state_d = READ_REQ;
                end
            end
            READ_LOAD: begin
                // never turn the pins around once the MCU has already released the bus
                if (noe_s || ne_s) begin
                    state_d = IDLE;
                end else begin
                    buf_oe_d = 1'b1;
                    state_d  = READ_DRIVE;
                end
            end
            READ_DRIVE: begin
                if (noe_s || ne_s) begin
                    state_d = IDLE;
                end else begin
                    buf_oe_d = 1'b1;
                    state_d  = READ_DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ne_sync_q  <= 3'b111;
            noe_sync_q <= 3'b111;
            nwe_sync_q <= 3'b111;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_data_q  <= '0;
            buf_inp_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            buf_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ne_sync_q  <= ne_sync_d;
            noe_sync_q <= noe_sync_d;
            nwe_sync_q <= nwe_sync_d;
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_data_q  <= wr_data_d;
            buf_inp_q  <= buf_inp_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            bus_err_q  <= bus_err_d;
            buf_oe_q   <= buf_oe_d;
        end
    end

    assign buf_inp = buf_inp_q;
    assign buf_oe  = buf_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_fsmc_slave_ctrl.sv
// Bench for fsmc_slave_ctrl: directed FSMC transactions against a cycle-scheduled model
// of pin-to-output latencies, plus literal expectations per scenario.
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif

module tb_fsmc_slave_ctrl;
    localparam int AW  = 8;
    localparam int DW  = `FSMC_WIDTH;
    localparam int TMO = 15;
    localparam int LAT = 3;   // pin change to first registered reaction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fsmc_ne, fsmc_noe, fsmc_nwe;
    logic [AW-1:0] fsmc_a;
    logic [DW-1:0] buf_outp, rd_data;
    logic          rd_valid;
    logic [DW-1:0] buf_inp, wr_data;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          buf_oe, wr_en, rd_req, bus_err;

    fsmc_slave_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .fsmc_ne(fsmc_ne), .fsmc_noe(fsmc_noe), .fsmc_nwe(fsmc_nwe), .fsmc_a(fsmc_a),
        .buf_outp(buf_outp), .buf_inp(buf_inp), .buf_oe(buf_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected pulses / level windows keyed by cycle, and value updates keyed by cycle.
    bit            exp_wr_en[int], exp_rd_req[int], exp_err[int], exp_oe[int];
    logic [AW-1:0] sch_wr_addr[int], sch_rd_addr[int];
    logic [DW-1:0] sch_wr_data[int], sch_inp[int];
    logic [AW-1:0] m_wr_addr = '0, m_rd_addr = '0;
    logic [DW-1:0] m_wr_data = '0, m_inp = '0;

    int n_wr = 0, n_rdq = 0, n_err = 0, n_oe = 0;
    int last_rdq_cyc = 0, last_err_cyc = 0;
    logic          prev_oe = 1'b0;
    logic [DW-1:0] inp_prev = '0, inp_before_oe = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        #2;
        if (rst) begin
            m_wr_addr = '0;
            m_rd_addr = '0;
            m_wr_data = '0;
            m_inp     = '0;
            prev_oe   = 1'b0;
            inp_prev  = '0;
        end else begin
            if (sch_wr_addr.exists(cyc)) m_wr_addr = sch_wr_addr[cyc];
            if (sch_wr_data.exists(cyc)) m_wr_data = sch_wr_data[cyc];
            if (sch_rd_addr.exists(cyc)) m_rd_addr = sch_rd_addr[cyc];
            if (sch_inp.exists(cyc))     m_inp     = sch_inp[cyc];
            chk("wr_en",   32'(wr_en),   32'(exp_wr_en.exists(cyc)));
            chk("rd_req",  32'(rd_req),  32'(exp_rd_req.exists(cyc)));
            chk("bus_err", 32'(bus_err), 32'(exp_err.exists(cyc)));
            chk("buf_oe",  32'(buf_oe),  32'(exp_oe.exists(cyc)));
            chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            chk("wr_data", 32'(wr_data), 32'(m_wr_data));
            chk("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
            chk("buf_inp", 32'(buf_inp), 32'(m_inp));
            if (wr_en) n_wr++;
            if (rd_req) begin n_rdq++; last_rdq_cyc = cyc; end
            if (bus_err) begin n_err++; last_err_cyc = cyc; end
            if (buf_oe) n_oe++;
            if (buf_oe && !prev_oe) inp_before_oe = inp_prev;
            prev_oe  = buf_oe;
            inp_prev = buf_inp;
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int low_len);
        int c1, c2;
        @(negedge clk); fsmc_a = a; buf_outp = d; fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_nwe = 1'b0; c1 = cyc;
        sch_wr_addr[c1 + LAT] = a;
        repeat (low_len) @(negedge clk);
        fsmc_nwe = 1'b1; c2 = cyc;
        exp_wr_en[c2 + LAT]   = 1'b1;
        sch_wr_data[c2 + LAT] = d;
        repeat (LAT) @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // delay < 0: the register file never answers and the read times out.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay, input int hold);
        int c, r, v;
        logic [DW-1:0] inp;
        @(negedge clk); fsmc_a = a; rd_data = d; fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_noe = 1'b0; c = cyc;
        r = c + LAT;
        exp_rd_req[r]  = 1'b1;
        sch_rd_addr[r] = a;
        if (delay >= 0) begin
            v   = r + delay;
            inp = d;
        end else begin
            v   = r + TMO - 1;
            inp = '1;
            exp_err[v + 1] = 1'b1;
        end
        sch_inp[v + 1] = inp;
        for (int k = v + 2; k <= c + hold + 2; k++) exp_oe[k] = 1'b1;
        for (int k = c + 1; k <= c + hold + 6; k++) begin
            @(negedge clk);
            rd_valid = (delay >= 0) && (cyc == v);
            if (cyc == c + hold)     fsmc_noe = 1'b1;
            if (cyc == c + hold + 2) fsmc_ne  = 1'b1;
        end
        rd_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c, u, r, e0, w0, q0, o0;
        fsmc_ne = 1'b1; fsmc_noe = 1'b1; fsmc_nwe = 1'b1;
        fsmc_a = '0; buf_outp = '0; rd_data = '0; rd_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_buf_oe",  32'(buf_oe),  32'd0);
        chk("rst_buf_inp", 32'(buf_inp), 32'd0);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // plain write
        do_write(8'h12, 16'h005A, 6);
        chk("lit_wr_addr", 32'(wr_addr), 32'h12);
        chk("lit_wr_data", 32'(wr_data), 32'h5A);
        chk("lit_wr_count", 32'(n_wr), 32'd1);
        chk("lit_no_oe_in_write", 32'(n_oe), 32'd0);

        // read answered in the request cycle
        o0 = n_oe;
        do_read(8'h34, 16'h00C3, 0, 8);
        chk("lit_rd_addr", 32'(rd_addr), 32'h34);
        chk("lit_rd_inp", 32'(buf_inp), 32'hC3);
        chk("lit_inp_before_oe", 32'(inp_before_oe), 32'hC3);
        chk("lit_oe_len", 32'(n_oe - o0), 32'd6);

        // read answered four cycles late
        do_read(8'h7E, 16'h9696, 4, 12);
        chk("lit_rd_addr_dly", 32'(rd_addr), 32'h7E);
        chk("lit_rd_inp_dly", 32'(buf_inp), 32'h9696);

        // read timeout
        e0 = n_err;
        do_read(8'h40, 16'h0BAD, -1, 22);
        chk("lit_tmo_inp", 32'(buf_inp), 32'hFFFF);
        chk("lit_tmo_latency", 32'(last_err_cyc - last_rdq_cyc), 32'd15);
        chk("lit_tmo_err_count", 32'(n_err - e0), 32'd1);

        // noe and nwe low together
        e0 = n_err; w0 = n_wr; q0 = n_rdq;
        @(negedge clk); fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_noe = 1'b0; fsmc_nwe = 1'b0; c = cyc;
        exp_err[c + LAT] = 1'b1;
        repeat (4) @(negedge clk);
        fsmc_noe = 1'b1; fsmc_nwe = 1'b1;
        repeat (2) @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (6) @(negedge clk);
        chk("lit_illegal_err", 32'(n_err - e0), 32'd1);
        chk("lit_illegal_no_wr", 32'(n_wr - w0), 32'd0);
        chk("lit_illegal_no_rd", 32'(n_rdq - q0), 32'd0);

        // ne released in the middle of a write
        e0 = n_err; w0 = n_wr;
        @(negedge clk); fsmc_a = 8'h21; fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_nwe = 1'b0; c = cyc;
        sch_wr_addr[c + LAT] = 8'h21;
        repeat (5) @(negedge clk);
        fsmc_ne = 1'b1; u = cyc;
        exp_err[u + LAT] = 1'b1;
        repeat (3) @(negedge clk);
        fsmc_nwe = 1'b1;
        repeat (6) @(negedge clk);
        chk("lit_wabort_no_wr", 32'(n_wr - w0), 32'd0);
        chk("lit_wabort_err", 32'(n_err - e0), 32'd1);
        chk("lit_wabort_addr", 32'(wr_addr), 32'h21);

        // ne released while the read request is outstanding
        e0 = n_err; o0 = n_oe;
        @(negedge clk); fsmc_a = 8'h66; fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_noe = 1'b0; c = cyc;
        exp_rd_req[c + LAT]  = 1'b1;
        sch_rd_addr[c + LAT] = 8'h66;
        repeat (5) @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
        fsmc_noe = 1'b1;
        repeat (25) @(negedge clk);
        chk("lit_rabort_no_oe", 32'(n_oe - o0), 32'd0);
        chk("lit_rabort_no_err", 32'(n_err - e0), 32'd0);

        // reset while driving the pins
        @(negedge clk); fsmc_a = 8'h3C; rd_data = 16'h1234; fsmc_ne = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_noe = 1'b0; c = cyc;
        r = c + LAT;
        exp_rd_req[r]  = 1'b1;
        sch_rd_addr[r] = 8'h3C;
        sch_inp[r + 1] = 16'h1234;
        exp_oe[r + 2]  = 1'b1;
        exp_oe[r + 3]  = 1'b1;
        repeat (LAT) @(negedge clk);
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("lit_async_rst_oe", 32'(buf_oe), 32'd0);
        repeat (2) @(negedge clk);
        fsmc_noe = 1'b1; fsmc_ne = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        do_read(8'h55, 16'h00A5, 2, 10);
        chk("lit_post_rst_addr", 32'(rd_addr), 32'h55);
        chk("lit_post_rst_inp", 32'(buf_inp), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsmc_slave_ctrl.md
Name: fsmc_slave_ctrl

Overview:
Bus-side controller for the FPGA's FSMC data-pin buffer. It decodes the MCU's FSMC control strobes (NE/NOE/NWE) and address, turns MCU writes into single-cycle internal write strobes, and services MCU reads by fetching data from internal registers. On reads it loads the buffer's registered output path and enables the buffer's output at the correct cycle. It sits between the FSMC pins/buffer and the internal register file.

Parameters:
ADDR_W, 8, width of FSMC address bus and internal register address
TIMEOUT, 15, max clk cycles from rd_req to rd_valid before the read is failed (4-bit counter sufficient for default; counter width $clog2(TIMEOUT+1))

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
fsmc_ne  input  1  FSMC chip select, active low, asynchronous to clk
fsmc_noe  input  1  FSMC output enable (read strobe), active low, async
fsmc_nwe  input  1  FSMC write enable, active low, async
fsmc_a  input  ADDR_W  FSMC address, async, stable while strobe low
buf_outp  input  `FSMC_WIDTH  data sampled from pins by the buffer (already one clk registered)
buf_inp  output  `FSMC_WIDTH  data for the buffer to drive (buffer registers it one clk)
buf_oe  output  1  buffer output enable (combinational at buffer into tristate)
wr_en  output  1  one-cycle internal write strobe
wr_addr  output  ADDR_W  internal write address
wr_data  output  `FSMC_WIDTH  internal write data
rd_req  output  1  one-cycle internal read request
rd_addr  output  ADDR_W  internal read address
rd_data  input  `FSMC_WIDTH  read data, valid when rd_valid
rd_valid  input  1  read data valid; may be same cycle as rd_req or later
bus_err  output  1  one-cycle pulse on protocol error or read timeout

Behaviour:
- Reset (async, rst=1): all outputs 0; synchronizer flops for ne/noe/nwe = 1; state IDLE; timeout counter 0.
- ne/noe/nwe each pass a 2-flop synchronizer; edges detected on synchronized versions (ne_s, noe_s, nwe_s). fsmc_a sampled only in the cycles named below (stable by protocol).
- States: IDLE, WRITE, READ_REQ, READ_LOAD, READ_DRIVE.
- IDLE: ne_s=0 and nwe_s falling -> capture fsmc_a into wr_addr, go WRITE. ne_s=0 and noe_s falling -> capture fsmc_a into rd_addr, pulse rd_req, go READ_REQ. Both noe_s and nwe_s low in same cycle -> bus_err pulse, stay IDLE.
- WRITE: on nwe_s rising -> wr_data <= buf_outp, wr_en=1 for exactly that next cycle, return IDLE. ne_s rising before nwe_s rises -> abort, no wr_en, bus_err pulse, IDLE.
- READ_REQ: counter increments each cycle. rd_valid=1 (including cycle of rd_req) -> buf_inp <= rd_data, go READ_LOAD. Counter reaches TIMEOUT -> buf_inp <= all ones, bus_err pulse, go READ_LOAD. noe_s or ne_s rising -> IDLE, no drive.
- READ_LOAD: one cycle so buffer registers buf_inp; buf_oe stays 0. Go READ_DRIVE.
- READ_DRIVE: buf_oe=1. Holds until noe_s or ne_s goes 1; buf_oe deasserts the cycle after that detection; IDLE.
- Latency: write strobe 1 clk after synchronized nwe rise (3 clk after pin); read data on pins 2 clk after rd_valid.
- nwe activity outside IDLE/WRITE ignored. buf_oe never asserted outside READ_DRIVE. Reset mid-transaction drops buf_oe immediately, no wr_en.
- Counter cleared on entry to READ_REQ.

Test Plan:
- Write: ne=0, a=0x12, nwe low 6 clk then high, buf_outp=0x5A -> single wr_en pulse, wr_addr=0x12, wr_data=0x5A, buf_oe stays 0.
- Read, immediate valid: a=0x34, noe low, rd_valid with rd_req, rd_data=0xC3 -> rd_addr=0x34, buf_inp=0xC3 one clk before buf_oe=1; buf_oe drops one clk after noe_s rise.
- Read timeout: rd_valid never asserted -> bus_err after 15 clk, buf_inp=all ones, then buf_oe=1 until noe high.
- Illegal strobes: noe and nwe driven low together -> bus_err pulse, no rd_req, no wr_en, IDLE.
- Abort: ne rises mid-write before nwe rises -> no wr_en, bus_err; ne rises during READ_REQ -> buf_oe never asserted.
- Reset during READ_DRIVE -> buf_oe=0 same cycle asynchronously; next noe fall restarts a clean read.
